sir_bus_master: RTL and testbench
=================================

// Module: sir_bus_master
// PURPOSE
//  Initiator side of the Sir register bus. Takes single read/write commands over a
//  valid/ready interface, drives SirSel/SirAddr/SirRead/SirWdat to the CSR slave banks,
//  waits for SirDack with a timeout, and returns SirRdat plus an error flag on a
//  valid/ready response channel. One transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W   16   Sir address width.
//  DATA_W   32   Sir data width.
//  TIMEOUT  64   WAIT cycles without SirDack before error response; legal range 2..65535.
// PORTS
//  clk        in   1       Clock.
//  rst        in   1       Reset: synchronous, active-high.
//  cmd_valid  in   1       Command request.
//  cmd_ready  out  1       Command accept; high only in IDLE.
//  cmd_read   in   1       1 = read, 0 = write.
//  cmd_addr   in   ADDR_W  Target register address.
//  cmd_wdat   in   DATA_W  Write data; ignored for reads.
//  rsp_valid  out  1       Response available.
//  rsp_ready  in   1       Response accept.
//  rsp_rdat   out  DATA_W  Read data; 0 for writes and for timeouts.
//  rsp_err    out  1       1 = timeout, no SirDack received.
//  busy       out  1       High in any state other than IDLE.
//  SirAddr    out  ADDR_W  Bus address.
//  SirRead    out  1       Bus read qualifier.
//  SirWdat    out  DATA_W  Bus write data.
//  SirSel     out  1       One-cycle access strobe.
//  SirDack    in   1       OR of all slave acks, registered at the slave side.
//  SirRdat    in   DATA_W  OR of all slave read data; 0 from non-addressed slaves.
// BEHAVIOUR
//  Reset values:
//   - State IDLE; SirSel = 0, rsp_valid = 0, busy = 0.
//   - SirAddr, SirRead, SirWdat, rsp_rdat, rsp_err all 0.
//   - cmd_ready = 1 from the first cycle after reset.
//  FSM states: IDLE -> SEL -> WAIT -> RSP -> IDLE.
//  IDLE:
//   - cmd_ready = 1. Handshake at cycle T (cmd_valid & cmd_ready).
//   - At T, register cmd_addr, cmd_read and cmd_wdat into SirAddr, SirRead, SirWdat.
//   - Go to SEL.
//  SEL (cycle T+1):
//   - SirSel = 1 for exactly this one cycle.
//   - Clear the timeout counter. Go to WAIT.
//  WAIT (from cycle T+2):
//   - SirSel = 0. SirAddr, SirRead and SirWdat stay stable until the state leaves RSP.
//   - SirDack = 1 -> capture SirRdat into rsp_rdat (forced to 0 for writes).
//     Set rsp_err = 0. Go to RSP.
//   - Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no
//     SirDack, set rsp_rdat = 0 and rsp_err = 1, then go to RSP.
//   - SirDack in the same cycle as the terminal count is a success: SirDack wins.
//   - Net effect: SirDack is accepted in WAIT cycles 0..TIMEOUT-1.
//  RSP:
//   - rsp_valid = 1; rsp_rdat and rsp_err are held stable.
//   - On rsp_valid & rsp_ready, go to IDLE. The next command can be accepted in the
//     following cycle.
//  SirDack outside WAIT (IDLE, SEL, RSP) is ignored: no state change, rsp_* unaffected.
//  SirRdat is sampled only in the cycle in which SirDack is accepted.
//  Minimum latency from handshake to rsp_valid: SirDack at T+2 -> rsp_valid at T+3.
//  The counter width is $clog2(TIMEOUT). The counter saturates and never wraps.
//  rst asserted mid-operation:
//   - Abort and return to the reset values in the next cycle. No response is issued.
//   - A late SirDack arrives while in IDLE and is ignored.
// TESTING
//  1. Write 0x3004 <- 0x00000001; SirDack asserted 2 cycles after SirSel
//     -> exactly one SirSel pulse; SirWdat = 1 held; rsp_err = 0, rsp_rdat = 0.
//  2. Read 0x300c; slave returns 0x12345678 with SirDack
//     -> rsp_rdat = 0x12345678, rsp_err = 0.
//  3. Read 0x3fff with no slave responding (TIMEOUT = 64)
//     -> rsp_valid exactly 64 cycles after entering WAIT; rsp_err = 1, rsp_rdat = 0.
//  4. SirDack in WAIT cycle 63 (TIMEOUT = 64) -> success, rsp_err = 0.
//     SirDack one cycle later -> timeout, and that SirDack is ignored.
//  5. rsp_ready held low for 10 cycles -> rsp_valid, rsp_rdat and rsp_err stable;
//     cmd_ready = 0 throughout; the next cmd is accepted the cycle after the rsp handshake.
//  6. rst pulsed during WAIT, then SirDack arrives after reset
//     -> no rsp_valid, SirSel = 0, cmd_ready = 1.
//     Spurious SirDack while IDLE -> no effect.

Source files
------------

// File: rtl/sir_bus_master.sv
// sir_bus_master: single-outstanding initiator for the Sir register bus with ack timeout
module sir_bus_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_read,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdat,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdat,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] SirAddr,
    output logic              SirRead,
    output logic [DATA_W-1:0] SirWdat,
    output logic              SirSel,
    input  logic              SirDack,
    input  logic [DATA_W-1:0] SirRdat
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SEL, WAIT, RSP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          last;

    assign last = cnt == CW'(TIMEOUT - 1);

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and state-decoded outputs; an ack on the terminal count still wins
    always_comb begin
        state_nx  = state == IDLE ? (cmd_valid ? SEL : IDLE)
                  : state == SEL  ? WAIT
                  : state == WAIT ? ((SirDack || last) ? RSP : WAIT)
                  : (rsp_ready ? IDLE : RSP);
        cmd_ready = state == IDLE;
        SirSel    = state == SEL;
        rsp_valid = state == RSP;
        busy      = state != IDLE;
    end

    // command capture, saturating wait counter and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            SirAddr  <= '0;
            SirRead  <= 1'b0;
            SirWdat  <= '0;
            cnt      <= '0;
            rsp_rdat <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                SirAddr <= cmd_addr;
                SirRead <= cmd_read;
                SirWdat <= cmd_wdat;
            end
            if (state == SEL)
                cnt <= '0;
            else if (state == WAIT && !last)
                cnt <= cnt + CW'(1);
            if (state == WAIT && (SirDack || last)) begin
                rsp_rdat <= (SirDack && SirRead) ? SirRdat : '0;
                rsp_err  <= !SirDack;
            end
        end
    end
endmodule

// File: tb/tb_sir_bus_master.sv
// tb_sir_bus_master: directed table plus randomized transactions against a latency/result model
module tb_sir_bus_master;
    localparam int TIMEOUT = 64;

    logic        clk = 0;
    logic        rst = 1;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic        cmd_read = 0;
    logic [15:0] cmd_addr = 0;
    logic [31:0] cmd_wdat = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [31:0] rsp_rdat;
    logic        rsp_err;
    logic        busy;
    logic [15:0] SirAddr;
    logic        SirRead;
    logic [31:0] SirWdat;
    logic        SirSel;
    logic        SirDack = 0;
    logic [31:0] SirRdat = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd;
        logic [15:0] addr;
        logic [31:0] wdat;
        int          dack;
        logic [31:0] srd;
        int          rdy;
        bit          e_err;
        logic [31:0] e_rdat;
        int          e_lat;
    } vec_t;

    vec_t tab [7];

    sir_bus_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdat(cmd_wdat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdat(rsp_rdat), .rsp_err(rsp_err),
        .busy(busy),
        .SirAddr(SirAddr), .SirRead(SirRead), .SirWdat(SirWdat), .SirSel(SirSel),
        .SirDack(SirDack), .SirRdat(SirRdat)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    // an ack is accepted in WAIT cycles 0..TIMEOUT-1; rsp_valid follows one cycle after acceptance
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.e_err  = v.dack < 0 || v.dack >= TIMEOUT;
        m.e_rdat = (!m.e_err && v.rd) ? v.srd : 32'h0;
        m.e_lat  = m.e_err ? TIMEOUT : v.dack + 1;
        return m;
    endfunction

    task automatic check_idle_reset(input string n);
        chk({n, "_sel"}, 64'(SirSel), 64'(0));
        chk({n, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        chk({n, "_busy"}, 64'(busy), 64'(0));
        chk({n, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({n, "_bus"}, 64'({SirRead, SirAddr, SirWdat}), 64'(0));
        chk({n, "_rsp"}, 64'({rsp_err, rsp_rdat}), 64'(0));
    endtask

    task automatic txn(input vec_t v, input bit spur);
        int wc;
        int sels;
        chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1; cmd_read = v.rd; cmd_addr = v.addr; cmd_wdat = v.wdat;
        @(posedge clk); @(negedge clk);
        cmd_valid = 0; cmd_read = 1'($urandom); cmd_addr = 16'($urandom); cmd_wdat = $urandom;
        sels = 0;
        sels += int'(SirSel);
        chk("sel_strobe", 64'(SirSel), 64'(1));
        chk("sel_bus", 64'({SirRead, SirAddr, SirWdat}), 64'({v.rd, v.addr, v.wdat}));
        chk("sel_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("sel_busy", 64'(busy), 64'(1));
        SirDack = spur; SirRdat = $urandom;
        @(posedge clk); @(negedge clk);
        wc = 0;
        while (!rsp_valid && wc < TIMEOUT + 8) begin
            sels += int'(SirSel);
            chk("wait_bus_hold", 64'({SirRead, SirAddr, SirWdat}), 64'({v.rd, v.addr, v.wdat}));
            SirDack = wc == v.dack;
            SirRdat = SirDack ? v.srd : $urandom;
            wc++;
            @(posedge clk); @(negedge clk);
        end
        chk("latency", 64'(wc), 64'(v.e_lat));
        for (int r = 0; r <= v.rdy; r++) begin
            sels += int'(SirSel);
            chk("rsp_valid", 64'(rsp_valid), 64'(1));
            chk("rsp_err", 64'(rsp_err), 64'(v.e_err));
            chk("rsp_rdat", 64'(rsp_rdat), 64'(v.e_rdat));
            chk("rsp_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("rsp_bus_hold", 64'({SirRead, SirAddr, SirWdat}), 64'({v.rd, v.addr, v.wdat}));
            SirDack = wc == v.dack;
            SirRdat = $urandom;
            wc++;
            rsp_ready = r == v.rdy;
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 0; SirDack = 0; SirRdat = 0;
        chk("sel_pulses", 64'(sels), 64'(1));
        chk("post_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("post_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("post_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        vec_t v;
        tab[0] = '{1'b0, 16'h3004, 32'h00000001, 1,  32'h00000000, 0,  1'b0, 32'h00000000, 2};
        tab[1] = '{1'b1, 16'h300c, 32'h00000000, 0,  32'h12345678, 0,  1'b0, 32'h12345678, 1};
        tab[2] = '{1'b1, 16'h3fff, 32'h00000000, -1, 32'h00000000, 0,  1'b1, 32'h00000000, 64};
        tab[3] = '{1'b1, 16'h3010, 32'h00000000, 63, 32'hdeadbeef, 0,  1'b0, 32'hdeadbeef, 64};
        tab[4] = '{1'b1, 16'h3014, 32'h00000000, 64, 32'hcafef00d, 0,  1'b1, 32'h00000000, 64};
        tab[5] = '{1'b1, 16'h3020, 32'h00000000, 3,  32'ha5a5a5a5, 10, 1'b0, 32'ha5a5a5a5, 4};
        tab[6] = '{1'b0, 16'h3024, 32'hffffffff, 0,  32'h87654321, 1,  1'b0, 32'h00000000, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        check_idle_reset("reset");

        for (int i = 0; i < 7; i++) txn(tab[i], 1'b0);

        cmd_valid = 1; cmd_read = 1; cmd_addr = 16'h3030; cmd_wdat = 32'h13572468;
        @(posedge clk); @(negedge clk);
        cmd_valid = 0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
        check_idle_reset("mid_rst");
        SirDack = 1; SirRdat = 32'h55aa55aa;
        @(posedge clk); @(negedge clk);
        SirDack = 0; SirRdat = 0;
        repeat (3) begin
            check_idle_reset("late_dack");
            @(posedge clk); @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            v.rd   = 1'($urandom);
            v.addr = 16'($urandom);
            v.wdat = $urandom;
            v.srd  = $urandom;
            case ($urandom % 4)
                0:       v.dack = -1;
                1:       v.dack = int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
                default: v.dack = int'($urandom_range(0, 7));
            endcase
            v.rdy = int'($urandom_range(0, 3));
            txn(model(v), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
